seq_detector_param: RTL

//   Parametrised serial bit-pattern detector. Generalises the fixed 4-bit 1101 Mealy detector.
//   - Pattern length and default pattern are parameters; the pattern can be reloaded at run time.
//   - Overlapping or non-overlapping match mode is selectable.
//   - Provides a Mealy match strobe, a registered strobe and a saturating match counter.
//   - Sits between the debounced serial input stage and the multi-digit display; the display shows the count.

---
 rtl/seq_detector_param_pkg.sv | 24 ++
 rtl/seq_detector_param_sat_counter.sv | 39 +++
 rtl/seq_detector_param.sv | 92 +++++++++
 3 files changed

// File: rtl/seq_detector_param_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_detector_param_pkg                                                     |
// | Shared defaults and helpers for the parametrised serial pattern detector.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package seq_detector_param_pkg;

  localparam int          DEF_PAT_LEN = 4;
  localparam logic [15:0] DEF_PATTERN = 16'b0000_0000_0000_1101;
  localparam bit          OVERLAP_OFF = 1'b0;
  localparam bit          OVERLAP_ON  = 1'b1;
  localparam int          DEF_CNT_W   = 8;

  // Never returns less than 1 so a width derived from it is always legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detector_param_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sat_counter                                                                |
// | Saturating up-counter; clear takes priority over increment.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sat_counter
  import seq_detector_param_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;

  always_comb begin
    q_d = q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q != '1)) begin
      q_d = q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_detector_param                                                         |
// | Serial bit-pattern detector with reloadable pattern, overlap mode select,  |
// | Mealy/registered match strobes and a saturating match counter.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
  parameter bit                 OVERLAP = OVERLAP_ON,
  parameter int                 CNT_W   = DEF_CNT_W,
  localparam int                FILL_W  = clog2(PAT_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               en,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               clr_cnt,
  output logic               z,
  output logic               z_q,
  output logic [CNT_W-1:0]   match_count,
  output logic [FILL_W-1:0]  fill
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pat_q;
  logic [PAT_LEN-1:0] pat_d;
  logic [PAT_LEN-2:0] hist_q;
  logic [PAT_LEN-2:0] hist_d;
  logic [FILL_W-1:0]  fill_q;
  logic [FILL_W-1:0]  fill_d;
  logic [PAT_LEN-1:0] w_window;
  logic               w_full;
  logic               w_match;

  always_comb begin
    // Slicing the full window keeps the shift legal down to PAT_LEN=2.
    w_window = {hist_q, x};
    w_full   = (fill_q == FILL_FULL);
    w_match  = en & ~load & ~reset & w_full & (w_window == pat_q);

    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (load) begin
      pat_d  = pat_in;
      fill_d = '0;
    end else if (en) begin
      hist_d = w_window[PAT_LEN-2:0];
      if (w_match && (OVERLAP == OVERLAP_OFF)) begin
        fill_d = '0;
      end else if (!w_full) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= w_match;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_match),
    .clr   (clr_cnt),
    .q     (match_count)
  );

  assign z    = w_match;
  assign fill = fill_q;

endmodule
`default_nettype wire
